// File: rtl/sram_arb_pkg.sv
// Shared definitions for the pixel SRAM window arbiter.
// Holds the FSM state type, requester port IDs and default bus widths.
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_DISP   = 2'd0,
        ST_ARB    = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker with a last-grant pointer.
// Ports: clk/rst, req[1:0] (bit0 = A), en gates all grants, gnt[1:0] one-hot.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == PORT_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = PORT_A;
        end else if (gnt[1]) begin
            last_d = PORT_B;
        end
    end

    // Pointer starts on B so that A wins the first contested cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_window_arbiter.sv
// Shares the pixel SRAM between scan-out and two requesters (A, B).
// Display owns the bus in active video; A/B get round-robin slots in blanking.
module sram_window_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iBLANK,
    input  logic              iPAUSE,
    input  logic [ADDR_W-1:0] iDISP_ADDR,
    output logic [DATA_W-1:0] oDISP_DATA,
    input  logic              iA_REQ,
    input  logic              iA_WE,
    input  logic [ADDR_W-1:0] iA_ADDR,
    input  logic [DATA_W-1:0] iA_WDATA,
    output logic              oA_GNT,
    output logic [DATA_W-1:0] oA_RDATA,
    output logic              oA_RVALID,
    output logic              oA_ABORT,
    input  logic              iB_REQ,
    input  logic              iB_WE,
    input  logic [ADDR_W-1:0] iB_ADDR,
    input  logic [DATA_W-1:0] iB_WDATA,
    output logic              oB_GNT,
    output logic [DATA_W-1:0] oB_RDATA,
    output logic              oB_RVALID,
    output logic              oB_ABORT,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic              oSRAM_WE_N,
    output logic [DATA_W-1:0] oSRAM_WDATA,
    output logic              oSRAM_DQ_OE,
    input  logic [DATA_W-1:0] iSRAM_RDATA,
    output logic [15:0]       oWIN_COUNT
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_n_q, we_n_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              port_q, port_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic              abort_a_q, abort_a_d;
    logic              abort_b_q, abort_b_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [1:0] gnt;
    logic       grant_en;
    logic       accept;
    logic       sel_b;

    assign grant_en = (state_q != ST_DISP) & iBLANK & ~iPAUSE;
    assign accept   = |gnt;
    assign sel_b    = gnt[1];

    rr_arb2 u_rr (
        .clk (iCLK),
        .rst (iRST),
        .req ({iB_REQ, iA_REQ}),
        .en  (grant_en),
        .gnt (gnt)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_DISP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DISP: begin
                state_d = iBLANK ? ST_ARB : ST_DISP;
            end
            ST_ARB, ST_ACCESS: begin
                if (!iBLANK) begin
                    state_d = ST_DISP;
                end else if (accept) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_DISP;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        we_n_d     = 1'b1;
        wdata_d    = wdata_q;
        port_d     = port_q;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        abort_a_d  = 1'b0;
        abort_b_d  = 1'b0;
        cnt_d      = cnt_q;

        // Close out a read: data is only trusted if blanking held
        // through the whole SRAM cycle.
        if (state_q == ST_ACCESS && we_n_q) begin
            if (iBLANK) begin
                if (port_q == PORT_B) begin
                    rdata_b_d  = iSRAM_RDATA;
                    rvalid_b_d = 1'b1;
                end else begin
                    rdata_a_d  = iSRAM_RDATA;
                    rvalid_a_d = 1'b1;
                end
            end else begin
                if (port_q == PORT_B) begin
                    abort_b_d = 1'b1;
                end else begin
                    abort_a_d = 1'b1;
                end
            end
        end

        // Scan-out address whenever the display owns the next cycle.
        if (state_q == ST_DISP || !iBLANK) begin
            addr_d = iDISP_ADDR;
        end

        // Count of the previous window survives active video and is
        // only cleared as the next window opens.
        if (state_q == ST_DISP && iBLANK) begin
            cnt_d = 16'd0;
        end

        if (accept) begin
            addr_d  = sel_b ? iB_ADDR : iA_ADDR;
            we_n_d  = sel_b ? ~iB_WE : ~iA_WE;
            wdata_d = sel_b ? iB_WDATA : iA_WDATA;
            port_d  = sel_b ? PORT_B : PORT_A;
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            wdata_q    <= '0;
            port_q     <= PORT_A;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            abort_a_q  <= 1'b0;
            abort_b_q  <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            addr_q     <= addr_d;
            we_n_q     <= we_n_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            abort_a_q  <= abort_a_d;
            abort_b_q  <= abort_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign oDISP_DATA  = iSRAM_RDATA;
    assign oA_GNT      = gnt[0];
    assign oB_GNT      = gnt[1];
    assign oA_RDATA    = rdata_a_q;
    assign oB_RDATA    = rdata_b_q;
    assign oA_RVALID   = rvalid_a_q;
    assign oB_RVALID   = rvalid_b_q;
    assign oA_ABORT    = abort_a_q;
    assign oB_ABORT    = abort_b_q;
    assign oSRAM_ADDR  = addr_q;
    assign oSRAM_WE_N  = we_n_q;
    assign oSRAM_WDATA = wdata_q;
    assign oSRAM_DQ_OE = ~we_n_q;
    assign oWIN_COUNT  = cnt_q;

endmodule

// File: tb/tb_sram_window_arbiter.sv
// Bench for sram_window_arbiter: window-level model plus directed scenarios.
// Ports all connected; a small behavioural SRAM answers the DQ input.
module tb_sram_window_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blank = 1'b0;
    logic        pause = 1'b0;
    logic [17:0] disp = '0;
    logic [15:0] disp_data;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [17:0] a_addr = '0;
    logic [15:0] a_wd = '0;
    logic        a_gnt, a_rv, a_ab;
    logic [15:0] a_rd;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [17:0] b_addr = '0;
    logic [15:0] b_wd = '0;
    logic        b_gnt, b_rv, b_ab;
    logic [15:0] b_rd;
    logic [17:0] s_addr;
    logic        s_we_n, s_oe;
    logic [15:0] s_wd, s_rd;
    logic [15:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_window_arbiter dut (
        .iCLK(clk), .iRST(rst), .iBLANK(blank), .iPAUSE(pause),
        .iDISP_ADDR(disp), .oDISP_DATA(disp_data),
        .iA_REQ(a_req), .iA_WE(a_we), .iA_ADDR(a_addr),
        .iA_WDATA(a_wd), .oA_GNT(a_gnt), .oA_RDATA(a_rd),
        .oA_RVALID(a_rv), .oA_ABORT(a_ab),
        .iB_REQ(b_req), .iB_WE(b_we), .iB_ADDR(b_addr),
        .iB_WDATA(b_wd), .oB_GNT(b_gnt), .oB_RDATA(b_rd),
        .oB_RVALID(b_rv), .oB_ABORT(b_ab),
        .oSRAM_ADDR(s_addr), .oSRAM_WE_N(s_we_n),
        .oSRAM_WDATA(s_wd), .oSRAM_DQ_OE(s_oe),
        .iSRAM_RDATA(s_rd), .oWIN_COUNT(cnt)
    );

    // Behavioural SRAM, aliased on the low address byte.
    logic [15:0] mem [0:255];
    always_comb s_rd = mem[s_addr[7:0]];
    always @(posedge clk) if (!s_we_n) mem[s_addr[7:0]] <= s_wd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Window-level model: is a blank window open, is a transaction
    // outstanding, and what every visible register must hold.
    logic        m_window, m_busy, m_last_a, m_we;
    int          m_port;
    logic [17:0] m_addr;
    logic [15:0] m_wd;
    logic [15:0] mmem [0:255];
    logic [17:0] e_addr;
    logic        e_wen;
    logic [15:0] e_wdata, e_cnt;
    logic [15:0] e_rd [2];
    logic [1:0]  e_rv, e_ab;

    function automatic logic [1:0] exp_gnt();
        if (rst || !m_window || !blank || pause) return 2'b00;
        if (a_req && b_req) return m_last_a ? 2'b10 : 2'b01;
        return {b_req, a_req};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        if (rst) begin
            m_window = 0; m_busy = 0; m_last_a = 0;
            e_addr = '0; e_wen = 1; e_wdata = '0; e_cnt = '0;
            e_rd[0] = '0; e_rd[1] = '0; e_rv = '0; e_ab = '0;
        end else begin
            g = exp_gnt();
            e_rv = '0;
            e_ab = '0;
            if (m_busy) begin
                if (m_we) mmem[m_addr[7:0]] = m_wd;
                else if (blank) begin
                    e_rd[m_port] = mmem[m_addr[7:0]];
                    e_rv[m_port] = 1'b1;
                end else e_ab[m_port] = 1'b1;
                m_busy = 0;
            end
            if (!m_window) begin
                e_addr = disp; e_wen = 1;
                if (blank) begin m_window = 1; e_cnt = '0; end
            end else if (!blank) begin
                m_window = 0; e_addr = disp; e_wen = 1;
            end else if (g != 2'b00) begin
                m_port = g[1] ? 1 : 0;
                m_we   = g[1] ? b_we : a_we;
                m_addr = g[1] ? b_addr : a_addr;
                m_wd   = g[1] ? b_wd : a_wd;
                m_busy = 1; m_last_a = g[0];
                e_addr = m_addr; e_wen = !m_we; e_wdata = m_wd;
                if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            end else e_wen = 1;
        end
    end

    always @(negedge clk) begin
        chk("gnt", {b_gnt, a_gnt}, exp_gnt());
        chk("sram_addr", s_addr, e_addr);
        chk("we_n", s_we_n, e_wen);
        chk("dq_oe", s_oe, !e_wen);
        chk("wdata", s_wd, e_wdata);
        chk("a_rdata", a_rd, e_rd[0]);
        chk("b_rdata", b_rd, e_rd[1]);
        chk("rvalid", {b_rv, a_rv}, e_rv);
        chk("abort", {b_ab, a_ab}, e_ab);
        chk("win_count", cnt, e_cnt);
        chk("disp_data", disp_data, s_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an A request and hold it until granted; returns #1
    // after the acceptance edge with the request dropped.
    task automatic req_a(input logic we, input logic [17:0] ad,
                         input logic [15:0] d);
        bit ok = 0;
        a_req = 1; a_we = we; a_addr = ad; a_wd = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_gnt) begin ok = 1; break; end
        end
        if (!ok) chk("a_req_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_req = 0;
    endtask

    initial begin
        logic [5:0] seq;
        // Reset with both requesters asking: no grant allowed.
        a_req = 1; a_we = 1; a_addr = 18'h00002; a_wd = 16'h1111;
        b_req = 1; b_we = 0; b_addr = 18'h00002;
        tick(); tick();
        @(negedge clk);
        chk("rst_gnt", {b_gnt, a_gnt}, 2'b00);
        chk("rst_we_n", s_we_n, 1'b1);
        tick();
        rst = 0;

        // Active video: scan-out address follows one cycle later.
        disp = 18'h12345;
        tick();
        @(negedge clk);
        chk("disp_addr", s_addr, 18'h12345);
        chk("disp_we_n", s_we_n, 1'b1);
        chk("disp_no_gnt", a_gnt, 1'b0);

        // Window 1: both ask for six cycles, grants alternate from A.
        blank = 1;
        tick();
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq[i] = b_gnt;
            chk("one_hot_gnt", a_gnt ^ b_gnt, 1'b1);
            tick();
        end
        a_req = 0; b_req = 0;
        chk("rr_sequence", seq, 6'b101010);
        @(negedge clk);
        chk("count6", cnt, 16'd6);
        tick();
        @(negedge clk);
        chk("b_read_1111", b_rd, 16'h1111);
        blank = 0;
        tick(); tick();

        // Window 2: single write, strobe for exactly one cycle.
        blank = 1;
        tick();
        req_a(1'b1, {9'd160, 9'd120}, 16'hF000);
        @(negedge clk);
        chk("w_we_n_low", s_we_n, 1'b0);
        chk("w_addr", s_addr, 18'h14078);
        chk("w_data", s_wd, 16'hF000);
        chk("w_count1", cnt, 16'd1);
        tick();
        @(negedge clk);
        chk("w_we_n_high", s_we_n, 1'b1);

        // Write then read back with blanking held.
        req_a(1'b1, 18'h00055, 16'h8000);
        req_a(1'b0, 18'h00055, 16'h0000);
        @(negedge clk);
        chk("rd_not_yet", a_rv, 1'b0);
        tick();
        @(negedge clk);
        chk("rd_rvalid", a_rv, 1'b1);
        chk("rd_data", a_rd, 16'h8000);

        // Read accepted on the last blank cycle is aborted.
        req_a(1'b0, 18'h00055, 16'h0000);
        blank = 0;
        disp = 18'h0ABCD;
        tick();
        @(negedge clk);
        chk("ab_abort", a_ab, 1'b1);
        chk("ab_no_rvalid", a_rv, 1'b0);
        chk("ab_disp_addr", s_addr, 18'h0ABCD);
        chk("ab_rdata_kept", a_rd, 16'h8000);
        disp = 18'h00777;
        tick();
        @(negedge clk);
        chk("ab_in_disp", s_addr, 18'h00777);
        chk("ab_pulse_end", a_ab, 1'b0);

        // Paused window: nothing granted, no write strobe.
        pause = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
        tick();
        blank = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("pause_gnt", {b_gnt, a_gnt}, 2'b00);
            chk("pause_we_n", s_we_n, 1'b1);
        end
        blank = 0; pause = 0; a_req = 0; b_req = 0;
        tick(); tick();

        // Reset during an in-flight write.
        blank = 1;
        tick();
        req_a(1'b1, 18'h00099, 16'hBEEF);
        #1;
        rst = 1;
        #1;
        chk("rst_mid_we_n", s_we_n, 1'b1);
        chk("rst_mid_oe", s_oe, 1'b0);
        chk("rst_mid_addr", s_addr, 18'h0);
        chk("rst_mid_wdata", s_wd, 16'h0);
        chk("rst_mid_count", cnt, 16'h0);
        chk("rst_mid_rdata", a_rd, 16'h0);
        tick(); tick();
        rst = 0;
        blank = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
